// File: rtl/strobe_rx_pkg.sv
// Shared types and constants for the receive-side strobe checker family.
package strobe_rx_pkg;

  // Checker FSM states, in the order the checker walks through them.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DLY = 3'd1,
    SEARCH   = 3'd2,
    ACQUIRE  = 3'd3,
    LOCKED   = 3'd4
  } state_e;

  // Default width of the saturating error counter.
  localparam int ERR_W_DEF = 16;

  // Width of the good/bad strobe streak counters (LOCK_CNT/UNLOCK_CNT <= 15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/strobe_rx_if.sv
// Received-word strobe stream plus checker status.
//
// Qualification rule: there is no backpressure. rx_strobe is meaningful only
// on cycles where rx_marker=1; on rx_marker=0 cycles rx_strobe is don't-care
// and the word is not counted. Status outputs are registered and valid every
// cycle.
interface strobe_rx_if #(
  parameter int ERR_W = strobe_rx_pkg::ERR_W_DEF
);
  logic             rx_marker;
  logic             rx_strobe;
  logic             locked;
  logic             strobe_err;
  logic [ERR_W-1:0] err_count;

  // Source of received words; observes checker status.
  modport master (
    output rx_marker, rx_strobe,
    input  locked, strobe_err, err_count
  );

  // The checker itself.
  modport slave (
    input  rx_marker, rx_strobe,
    output locked, strobe_err, err_count
  );
endinterface

// File: rtl/strobe_rx_start_timer.sv
// Start gate: on the first online cycle loads the delay, counts it down and
// flags the cycle whose clock edge begins searching. Returns to idle whenever
// online drops.
module strobe_rx_start_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        online,
  input  logic [15:0] delay_value,
  output logic        start
);

  logic        active_q, active_d;
  logic [15:0] tmr_q, tmr_d;

  // Timer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      active_q <= active_d;
      tmr_q    <= tmr_d;
    end
  end

  // delay_value is sampled only on the idle->active step; zero delay starts at once.
  always_comb begin
    active_d = active_q;
    tmr_d    = tmr_q;
    start    = 1'b0;
    if (!online) begin
      active_d = 1'b0;
      tmr_d    = '0;
    end else if (!active_q) begin
      active_d = 1'b1;
      tmr_d    = delay_value;
      start    = (delay_value == 16'd0);
    end else if (tmr_q != 16'd0) begin
      tmr_d = tmr_q - 16'd1;
      start = (tmr_q == 16'd1);
    end
  end

endmodule

// File: rtl/strobe_rx_check.sv
// Strobe alignment checker: finds the first strobe, requires LOCK_CNT good
// strobes to lock, then reports early/missing strobes while locked.
module strobe_rx_check
  import strobe_rx_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = ERR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] interval,
  input  logic [15:0] delay_value,
  input  logic        online,
  input  logic        err_clr,
  strobe_rx_if.slave  rx,
  output state_e      state_dbg
);

  state_e             state_q, state_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic               locked_q, locked_d;
  logic               strobe_err_q, strobe_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               start;
  logic               expected, on_time, fault;

  strobe_rx_start_timer u_start (
    .clk         (clk),
    .rst_n       (rst_n),
    .online      (online),
    .delay_value (delay_value),
    .start       (start)
  );

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      locked_q     <= 1'b0;
      strobe_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      locked_q     <= locked_d;
      strobe_err_q <= strobe_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Next-state logic and per-marker-word strobe evaluation.
  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    locked_d     = locked_q;
    strobe_err_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    // >= rather than == so a live interval decrease cannot strand word_cnt.
    expected     = (word_cnt_q >= interval);
    on_time      = rx.rx_strobe & expected;
    fault        = rx.rx_strobe ^ expected;

    if (!online) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE:     state_d = start ? SEARCH : WAIT_DLY;
        WAIT_DLY: if (start) state_d = SEARCH;
        SEARCH: begin
          if (rx.rx_marker && rx.rx_strobe) begin
            state_d    = ACQUIRE;
            word_cnt_d = '0;
            good_cnt_d = '0;
          end
        end
        ACQUIRE, LOCKED: begin
          if (rx.rx_marker) begin
            // Any strobe (good or early) or a missing one resyncs the word count.
            word_cnt_d = (on_time || fault) ? '0 : word_cnt_q + 16'd1;
            if (state_q == ACQUIRE) begin
              if (fault) begin
                good_cnt_d = '0;
              end else if (on_time) begin
                if (good_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
                  state_d    = LOCKED;
                  locked_d   = 1'b1;
                  good_cnt_d = '0;
                  bad_cnt_d  = '0;
                end else begin
                  good_cnt_d = good_cnt_q + CNT_W'(1);
                end
              end
            end else begin
              if (fault) begin
                strobe_err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                if (bad_cnt_q == CNT_W'(UNLOCK_CNT - 1)) begin
                  state_d   = SEARCH;
                  locked_d  = 1'b0;
                  bad_cnt_d = '0;
                end else begin
                  bad_cnt_d = bad_cnt_q + CNT_W'(1);
                end
              end else if (on_time) begin
                bad_cnt_d = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over a same-cycle increment; the strobe_err pulse is unaffected.
    if (err_clr) err_cnt_d = '0;
  end

  assign rx.locked     = locked_q;
  assign rx.strobe_err = strobe_err_q;
  assign rx.err_count  = err_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_strobe_rx_check.sv
// Randomized bench for strobe_rx_check: a transmit-style strobe generator with
// corruption feeds the DUT, a behavioural model predicts status per cycle into
// a queue, and a monitor compares on every falling edge.
module tb_strobe_rx_check;
  import strobe_rx_pkg::*;

  localparam int TB_ERR_W = 4;
  localparam int TB_LOCK  = 4;
  localparam int TB_UNLK  = 2;
  localparam int ERR_MAX  = (1 << TB_ERR_W) - 1;

  typedef struct packed {
    logic [31:0]         cyc;
    logic [2:0]          st;
    logic                lk;
    logic                se;
    logic [TB_ERR_W-1:0] ec;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] interval;
  logic [15:0] delay_value;
  logic        online;
  logic        err_clr;
  state_e      state_dbg;
  int          cyc_num = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_num <= cyc_num + 1;

  strobe_rx_if #(.ERR_W(TB_ERR_W)) rx_if ();

  strobe_rx_check #(
    .LOCK_CNT   (TB_LOCK),
    .UNLOCK_CNT (TB_UNLK),
    .ERR_W      (TB_ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .interval    (interval),
    .delay_value (delay_value),
    .online      (online),
    .err_clr     (err_clr),
    .rx          (rx_if.slave),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model ----------------
  // Phases numbered in the specification's state order.
  localparam int P_IDLE = 0, P_WAIT = 1, P_SEARCH = 2, P_ACQ = 3, P_LOCK = 4;
  int m_phase, m_dly, m_since, m_goods, m_bads, m_err;
  bit m_lock, m_pulse;

  task automatic model_step(input bit mk, input bit sb, input bit clr);
    bit exp_strobe;
    m_pulse = 0;
    if (!rst_n) begin
      m_phase = P_IDLE; m_dly = 0; m_since = 0; m_goods = 0; m_bads = 0;
      m_err = 0; m_lock = 0;
    end else begin
      if (!online) begin
        m_phase = P_IDLE; m_dly = 0; m_since = 0; m_goods = 0; m_bads = 0;
        m_lock = 0;
      end else if (m_phase == P_IDLE) begin
        if (delay_value == 0) m_phase = P_SEARCH;
        else begin m_phase = P_WAIT; m_dly = delay_value; end
      end else if (m_phase == P_WAIT) begin
        m_dly = m_dly - 1;
        if (m_dly == 0) m_phase = P_SEARCH;
      end else if (m_phase == P_SEARCH) begin
        if (mk && sb) begin m_phase = P_ACQ; m_since = 0; m_goods = 0; end
      end else if (mk) begin
        exp_strobe = (m_since >= int'(interval));
        m_since = (sb || exp_strobe) ? 0 : m_since + 1;
        if (m_phase == P_ACQ) begin
          if (sb != exp_strobe) m_goods = 0;
          else if (sb) begin
            m_goods++;
            if (m_goods == TB_LOCK) begin m_phase = P_LOCK; m_lock = 1; m_bads = 0; end
          end
        end else begin
          if (sb != exp_strobe) begin
            m_pulse = 1;
            if (m_err < ERR_MAX) m_err++;
            m_bads++;
            if (m_bads == TB_UNLK) begin m_phase = P_SEARCH; m_lock = 0; m_bads = 0; end
          end else if (sb) begin
            m_bads = 0;
          end
        end
      end
      if (clr) m_err = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: compare the status produced by the most recent rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0 && int'(exp_q[0].cyc) == cyc_num) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (3'(state_dbg) !== e.st || rx_if.locked !== e.lk ||
          rx_if.strobe_err !== e.se || rx_if.err_count !== e.ec) begin
        n_bad++;
        $display("FAIL status cyc%0d: got st=%0d locked=%b strobe_err=%b err_count=%0d, want st=%0d locked=%b strobe_err=%b err_count=%0d",
                 cyc_num, 3'(state_dbg), rx_if.locked, rx_if.strobe_err, rx_if.err_count,
                 e.st, e.lk, e.se, e.ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs, record the expected status after the next edge.
  task automatic step(input bit mk, input bit sb, input bit clr);
    exp_t e;
    rx_if.rx_marker = mk;
    rx_if.rx_strobe = sb;
    err_clr         = clr;
    model_step(mk, sb, clr);
    e.cyc = 32'(cyc_num + 1);
    e.st  = 3'(m_phase);
    e.lk  = m_lock;
    e.se  = m_pulse;
    e.ec  = TB_ERR_W'(m_err);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Transmit-style stream: strobe every interval+1 marker words, with random
  // marker gaps, random strobe corruption and random err_clr.
  int tx_cnt = 0;
  task automatic run_stream(input int n, input int gap_pct, input int flip_pct, input int clr_pct);
    bit mk, sb, nat, clr;
    for (int i = 0; i < n; i++) begin
      mk = ($urandom_range(0, 99) >= gap_pct);
      if (mk) begin
        nat = (tx_cnt >= int'(interval));
        sb  = nat;
        if ($urandom_range(0, 99) < flip_pct) sb = !sb;
        tx_cnt = nat ? 0 : tx_cnt + 1;
      end else begin
        sb = 1'($urandom_range(0, 1));
      end
      clr = ($urandom_range(0, 99) < clr_pct);
      step(mk, sb, clr);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; online = 1'b0; interval = 16'd9; delay_value = 16'd5;
    idle_cycles(3);

    // Clean stream at interval 9, delay 5: lock, no errors.
    rst_n = 1'b1; online = 1'b1;
    run_stream(300, 0, 0, 0);
    // Occasional dropped / early strobes while locked.
    run_stream(800, 0, 3, 0);
    // Live interval decrease with marker gaps.
    interval = 16'd7;
    run_stream(300, 10, 2, 0);
    // Strobe on every marker word, with gaps, then heavy corruption to saturate.
    interval = 16'd0;
    run_stream(300, 25, 0, 0);
    run_stream(800, 10, 25, 0);
    // Error clears interleaved with errors.
    run_stream(600, 10, 15, 6);

    // online drop mid-run keeps err_count; reset during the start delay.
    online = 1'b0;
    idle_cycles(2);
    online = 1'b1; delay_value = 16'd8;
    idle_cycles(3);
    rst_n = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1; interval = 16'd9; delay_value = 16'd0;
    run_stream(500, 5, 2, 2);
    delay_value = 16'd3; interval = 16'd4;
    online = 1'b0;
    idle_cycles(1);
    online = 1'b1;
    run_stream(400, 15, 4, 1);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
